// File: rtl/gpio_reg_if.sv
// Register-block <-> GPIO core field bundle (reg2hw q/qe toward the core, hw2reg d/de back).
interface gpio_reg_if;
  logic [31:0] reg2hw_intr_state_q;
  logic [31:0] reg2hw_intr_enable_q;
  logic [31:0] reg2hw_intr_test_q;
  logic        reg2hw_intr_test_qe;
  logic [31:0] reg2hw_direct_out_q;
  logic        reg2hw_direct_out_qe;
  logic [15:0] reg2hw_masked_out_lower_mask_q;
  logic [15:0] reg2hw_masked_out_lower_data_q;
  logic        reg2hw_masked_out_lower_qe;
  logic [15:0] reg2hw_masked_out_upper_mask_q;
  logic [15:0] reg2hw_masked_out_upper_data_q;
  logic        reg2hw_masked_out_upper_qe;
  logic [31:0] reg2hw_direct_oe_q;
  logic        reg2hw_direct_oe_qe;
  logic [15:0] reg2hw_masked_oe_lower_mask_q;
  logic [15:0] reg2hw_masked_oe_lower_data_q;
  logic        reg2hw_masked_oe_lower_qe;
  logic [15:0] reg2hw_masked_oe_upper_mask_q;
  logic [15:0] reg2hw_masked_oe_upper_data_q;
  logic        reg2hw_masked_oe_upper_qe;
  logic [31:0] reg2hw_intr_ctrl_en_rising_q;
  logic [31:0] reg2hw_intr_ctrl_en_falling_q;
  logic [31:0] reg2hw_intr_ctrl_en_lvlhigh_q;
  logic [31:0] reg2hw_intr_ctrl_en_lvllow_q;
  logic [31:0] reg2hw_ctrl_en_input_filter_q;

  logic [31:0] hw2reg_intr_state_d;
  logic        hw2reg_intr_state_de;
  logic [31:0] hw2reg_data_in_d;
  logic        hw2reg_data_in_de;
  logic [31:0] hw2reg_direct_out_d;
  logic [31:0] hw2reg_direct_oe_d;
  logic [15:0] hw2reg_masked_out_lower_data_d;
  logic [15:0] hw2reg_masked_out_lower_mask_d;
  logic [15:0] hw2reg_masked_out_upper_data_d;
  logic [15:0] hw2reg_masked_out_upper_mask_d;
  logic [15:0] hw2reg_masked_oe_lower_data_d;
  logic [15:0] hw2reg_masked_oe_lower_mask_d;
  logic [15:0] hw2reg_masked_oe_upper_data_d;
  logic [15:0] hw2reg_masked_oe_upper_mask_d;
  logic        hw2reg_straps_data_in_valid_d;
  logic        hw2reg_straps_data_in_valid_de;
  logic [31:0] hw2reg_straps_data_in_d;
  logic        hw2reg_straps_data_in_de;

  modport master (
    output reg2hw_intr_state_q, reg2hw_intr_enable_q, reg2hw_intr_test_q, reg2hw_intr_test_qe,
           reg2hw_direct_out_q, reg2hw_direct_out_qe,
           reg2hw_masked_out_lower_mask_q, reg2hw_masked_out_lower_data_q, reg2hw_masked_out_lower_qe,
           reg2hw_masked_out_upper_mask_q, reg2hw_masked_out_upper_data_q, reg2hw_masked_out_upper_qe,
           reg2hw_direct_oe_q, reg2hw_direct_oe_qe,
           reg2hw_masked_oe_lower_mask_q, reg2hw_masked_oe_lower_data_q, reg2hw_masked_oe_lower_qe,
           reg2hw_masked_oe_upper_mask_q, reg2hw_masked_oe_upper_data_q, reg2hw_masked_oe_upper_qe,
           reg2hw_intr_ctrl_en_rising_q, reg2hw_intr_ctrl_en_falling_q,
           reg2hw_intr_ctrl_en_lvlhigh_q, reg2hw_intr_ctrl_en_lvllow_q,
           reg2hw_ctrl_en_input_filter_q,
    input  hw2reg_intr_state_d, hw2reg_intr_state_de, hw2reg_data_in_d, hw2reg_data_in_de,
           hw2reg_direct_out_d, hw2reg_direct_oe_d,
           hw2reg_masked_out_lower_data_d, hw2reg_masked_out_lower_mask_d,
           hw2reg_masked_out_upper_data_d, hw2reg_masked_out_upper_mask_d,
           hw2reg_masked_oe_lower_data_d, hw2reg_masked_oe_lower_mask_d,
           hw2reg_masked_oe_upper_data_d, hw2reg_masked_oe_upper_mask_d,
           hw2reg_straps_data_in_valid_d, hw2reg_straps_data_in_valid_de,
           hw2reg_straps_data_in_d, hw2reg_straps_data_in_de
  );

  modport slave (
    input  reg2hw_intr_state_q, reg2hw_intr_enable_q, reg2hw_intr_test_q, reg2hw_intr_test_qe,
           reg2hw_direct_out_q, reg2hw_direct_out_qe,
           reg2hw_masked_out_lower_mask_q, reg2hw_masked_out_lower_data_q, reg2hw_masked_out_lower_qe,
           reg2hw_masked_out_upper_mask_q, reg2hw_masked_out_upper_data_q, reg2hw_masked_out_upper_qe,
           reg2hw_direct_oe_q, reg2hw_direct_oe_qe,
           reg2hw_masked_oe_lower_mask_q, reg2hw_masked_oe_lower_data_q, reg2hw_masked_oe_lower_qe,
           reg2hw_masked_oe_upper_mask_q, reg2hw_masked_oe_upper_data_q, reg2hw_masked_oe_upper_qe,
           reg2hw_intr_ctrl_en_rising_q, reg2hw_intr_ctrl_en_falling_q,
           reg2hw_intr_ctrl_en_lvlhigh_q, reg2hw_intr_ctrl_en_lvllow_q,
           reg2hw_ctrl_en_input_filter_q,
    output hw2reg_intr_state_d, hw2reg_intr_state_de, hw2reg_data_in_d, hw2reg_data_in_de,
           hw2reg_direct_out_d, hw2reg_direct_oe_d,
           hw2reg_masked_out_lower_data_d, hw2reg_masked_out_lower_mask_d,
           hw2reg_masked_out_upper_data_d, hw2reg_masked_out_upper_mask_d,
           hw2reg_masked_oe_lower_data_d, hw2reg_masked_oe_lower_mask_d,
           hw2reg_masked_oe_upper_data_d, hw2reg_masked_oe_upper_mask_d,
           hw2reg_straps_data_in_valid_d, hw2reg_straps_data_in_valid_de,
           hw2reg_straps_data_in_d, hw2reg_straps_data_in_de
  );
endinterface

// File: rtl/gpio_core.sv
// GPIO core: output/OE registers, synchronised + glitch-filtered inputs,
// interrupt event detection and one-shot strap capture after reset.
//
// Strap FSM
//   state      | meaning
//   ST_WAIT    | counting 3 clocks after reset release
//   ST_CAPTURE | one cycle: latch filtered inputs into the strap registers
//   ST_DONE    | straps held, no recapture until next reset
module gpio_core #(
  parameter int NumIO        = 32,
  parameter int FilterCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIO-1:0] cio_gpio_i,
  output logic [NumIO-1:0] cio_gpio_o,
  output logic [NumIO-1:0] cio_gpio_en_o,
  output logic [NumIO-1:0] intr_gpio_o,
  gpio_reg_if.slave        regs
);

  typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_DONE} strap_state_e;

  localparam logic [3:0] CntMax = 4'(FilterCycles - 1);

  logic [NumIO-1:0]      out_q, out_d, oe_q, oe_d;
  logic [NumIO-1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [NumIO-1:0][3:0] cnt_q, cnt_d;
  logic [NumIO-1:0]      ev;
  logic                  data_in_de_q;
  strap_state_e          state_q, state_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic                  capture;
  logic [NumIO-1:0]      straps_q;
  logic                  straps_valid_q, straps_de_q;

  function automatic logic [31:0] reg_write(
    input logic [31:0] cur,
    input logic        dir_qe,
    input logic [31:0] dir_q,
    input logic        lo_qe,
    input logic [15:0] lo_mask, lo_data,
    input logic        hi_qe,
    input logic [15:0] hi_mask, hi_data
  );
    logic [31:0] r;
    r = cur;
    if (dir_qe) begin
      r = dir_q;
    end else begin
      if (lo_qe) r[15:0]  = (cur[15:0]  & ~lo_mask) | (lo_data & lo_mask);
      if (hi_qe) r[31:16] = (cur[31:16] & ~hi_mask) | (hi_data & hi_mask);
    end
    return r;
  endfunction

  always_comb begin
    out_d = reg_write(out_q, regs.reg2hw_direct_out_qe, regs.reg2hw_direct_out_q,
                      regs.reg2hw_masked_out_lower_qe, regs.reg2hw_masked_out_lower_mask_q,
                      regs.reg2hw_masked_out_lower_data_q,
                      regs.reg2hw_masked_out_upper_qe, regs.reg2hw_masked_out_upper_mask_q,
                      regs.reg2hw_masked_out_upper_data_q);
    oe_d  = reg_write(oe_q, regs.reg2hw_direct_oe_qe, regs.reg2hw_direct_oe_q,
                      regs.reg2hw_masked_oe_lower_qe, regs.reg2hw_masked_oe_lower_mask_q,
                      regs.reg2hw_masked_oe_lower_data_q,
                      regs.reg2hw_masked_oe_upper_qe, regs.reg2hw_masked_oe_upper_mask_q,
                      regs.reg2hw_masked_oe_upper_data_q);
  end

  // Per-bit debounce: filt only follows sync2 after FilterCycles disagreeing samples
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int k = 0; k < NumIO; k++) begin
      if (!regs.reg2hw_ctrl_en_input_filter_q[k]) begin
        filt_d[k] = sync2_q[k];
      end else if (sync2_q[k] != filt_q[k]) begin
        if (cnt_q[k] == CntMax) filt_d[k] = sync2_q[k];
        else                    cnt_d[k]  = cnt_q[k] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      oe_q         <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      data_in_de_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      oe_q         <= oe_d;
      sync1_q      <= cio_gpio_i;
      sync2_q      <= sync1_q;
      filt_q       <= filt_d;
      prev_q       <= filt_q;
      cnt_q        <= cnt_d;
      data_in_de_q <= 1'b1;
    end
  end

  // Combinational interrupt paths are forced low while reset is held
  always_comb begin
    ev = (regs.reg2hw_intr_ctrl_en_rising_q  &  filt_q & ~prev_q) |
         (regs.reg2hw_intr_ctrl_en_falling_q & ~filt_q &  prev_q) |
         (regs.reg2hw_intr_ctrl_en_lvlhigh_q &  filt_q)           |
         (regs.reg2hw_intr_ctrl_en_lvllow_q  & ~filt_q);
    if (regs.reg2hw_intr_test_qe) ev = ev | regs.reg2hw_intr_test_q;
    if (!rst_ni) ev = '0;
  end

  assign regs.hw2reg_intr_state_d  = rst_ni ? (regs.reg2hw_intr_state_q | ev) : '0;
  assign regs.hw2reg_intr_state_de = |ev;
  assign intr_gpio_o = rst_ni ? (regs.reg2hw_intr_state_q & regs.reg2hw_intr_enable_q) : '0;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd2) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_WAIT;
      wcnt_q         <= 2'd0;
      straps_q       <= '0;
      straps_valid_q <= 1'b0;
      straps_de_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      straps_de_q    <= capture;
      straps_valid_q <= straps_valid_q | capture;
      if (capture) straps_q <= filt_q;
    end
  end

  assign cio_gpio_o    = out_q;
  assign cio_gpio_en_o = oe_q;

  assign regs.hw2reg_data_in_d               = filt_q;
  assign regs.hw2reg_data_in_de              = data_in_de_q;
  assign regs.hw2reg_direct_out_d            = out_q;
  assign regs.hw2reg_direct_oe_d             = oe_q;
  assign regs.hw2reg_masked_out_lower_data_d = out_q[15:0];
  assign regs.hw2reg_masked_out_upper_data_d = out_q[31:16];
  assign regs.hw2reg_masked_out_lower_mask_d = 16'h0;
  assign regs.hw2reg_masked_out_upper_mask_d = 16'h0;
  assign regs.hw2reg_masked_oe_lower_data_d  = oe_q[15:0];
  assign regs.hw2reg_masked_oe_upper_data_d  = oe_q[31:16];
  assign regs.hw2reg_masked_oe_lower_mask_d  = 16'h0;
  assign regs.hw2reg_masked_oe_upper_mask_d  = 16'h0;

  assign regs.hw2reg_straps_data_in_d        = straps_q;
  assign regs.hw2reg_straps_data_in_de       = straps_de_q;
  assign regs.hw2reg_straps_data_in_valid_d  = straps_valid_q;
  assign regs.hw2reg_straps_data_in_valid_de = straps_de_q;

endmodule

// File: tb/tb_gpio_core.sv
// Bench for gpio_core: directed scenarios plus random traffic, all checked every cycle
// against a bit-level behavioural model of the pad/register rules.
module tb_gpio_core;
  localparam int FC = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] pad;
  logic [31:0] cio_o, cio_en, intr_o;
  int          n_assert = 0;
  int          n_fail   = 0;

  gpio_reg_if rif();

  gpio_core #(.NumIO(32), .FilterCycles(FC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cio_gpio_i   (pad),
    .cio_gpio_o   (cio_o),
    .cio_gpio_en_o(cio_en),
    .intr_gpio_o  (intr_o),
    .regs         (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out, m_oe, m_s1, m_s2, m_filt, m_prev, m_strap;
  logic        m_valid, m_sde, m_din_de;
  int          m_streak [32];
  int          m_edges;

  function automatic logic [31:0] model_wr(input logic [31:0] cur, input logic dqe,
      input logic [31:0] dq, input logic lqe, input logic [15:0] lm, input logic [15:0] ld,
      input logic uqe, input logic [15:0] um, input logic [15:0] ud);
    logic [31:0] n;
    if (dqe) return dq;
    n = cur;
    for (int j = 0; j < 16; j++) begin
      if (lqe && lm[j]) n[j]      = ld[j];
      if (uqe && um[j]) n[j + 16] = ud[j];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_prev = '0;
      m_strap = '0; m_valid = 1'b0; m_sde = 1'b0; m_din_de = 1'b0; m_edges = 0;
      for (int i = 0; i < 32; i++) m_streak[i] = 0;
    end else begin
      logic [31:0] nf;
      m_edges++;
      if (m_edges == 4) begin
        m_strap = m_filt; m_valid = 1'b1; m_sde = 1'b1;
      end else begin
        m_sde = 1'b0;
      end
      m_out = model_wr(m_out, rif.reg2hw_direct_out_qe, rif.reg2hw_direct_out_q,
                       rif.reg2hw_masked_out_lower_qe, rif.reg2hw_masked_out_lower_mask_q,
                       rif.reg2hw_masked_out_lower_data_q, rif.reg2hw_masked_out_upper_qe,
                       rif.reg2hw_masked_out_upper_mask_q, rif.reg2hw_masked_out_upper_data_q);
      m_oe  = model_wr(m_oe, rif.reg2hw_direct_oe_qe, rif.reg2hw_direct_oe_q,
                       rif.reg2hw_masked_oe_lower_qe, rif.reg2hw_masked_oe_lower_mask_q,
                       rif.reg2hw_masked_oe_lower_data_q, rif.reg2hw_masked_oe_upper_qe,
                       rif.reg2hw_masked_oe_upper_mask_q, rif.reg2hw_masked_oe_upper_data_q);
      nf = m_filt;
      for (int i = 0; i < 32; i++) begin
        if (!rif.reg2hw_ctrl_en_input_filter_q[i]) begin
          nf[i] = m_s2[i]; m_streak[i] = 0;
        end else if (m_s2[i] == m_filt[i]) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i]++;
          if (m_streak[i] == FC) begin nf[i] = m_s2[i]; m_streak[i] = 0; end
        end
      end
      m_prev = m_filt; m_filt = nf; m_s2 = m_s1; m_s1 = pad;
      m_din_de = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    logic [31:0] ev;
    @(posedge clk); #1;
    ev = (rif.reg2hw_intr_ctrl_en_rising_q  &  m_filt & ~m_prev) |
         (rif.reg2hw_intr_ctrl_en_falling_q & ~m_filt &  m_prev) |
         (rif.reg2hw_intr_ctrl_en_lvlhigh_q &  m_filt) |
         (rif.reg2hw_intr_ctrl_en_lvllow_q  & ~m_filt) |
         (rif.reg2hw_intr_test_qe ? rif.reg2hw_intr_test_q : 32'h0);
    if (!rst_n) ev = '0;
    chk("cio_gpio_o", cio_o, m_out);
    chk("cio_gpio_en_o", cio_en, m_oe);
    chk("data_in_d", rif.hw2reg_data_in_d, m_filt);
    chk("intr_state_d", rif.hw2reg_intr_state_d,
        rst_n ? (rif.reg2hw_intr_state_q | ev) : 32'h0);
    chk("intr_gpio_o", intr_o,
        rst_n ? (rif.reg2hw_intr_state_q & rif.reg2hw_intr_enable_q) : 32'h0);
    chk("rb_direct_out", rif.hw2reg_direct_out_d, m_out);
    chk("rb_direct_oe", rif.hw2reg_direct_oe_d, m_oe);
    chk("rb_masked_data", {rif.hw2reg_masked_out_upper_data_d, rif.hw2reg_masked_oe_lower_data_d},
        {m_out[31:16], m_oe[15:0]});
    chk("rb_masked_data2", {rif.hw2reg_masked_oe_upper_data_d, rif.hw2reg_masked_out_lower_data_d},
        {m_oe[31:16], m_out[15:0]});
    chk("rb_masks", {rif.hw2reg_masked_out_lower_mask_d | rif.hw2reg_masked_out_upper_mask_d,
                     rif.hw2reg_masked_oe_lower_mask_d  | rif.hw2reg_masked_oe_upper_mask_d}, 32'h0);
    chk("straps_d", rif.hw2reg_straps_data_in_d, m_strap);
    chk("flags", {27'h0, rif.hw2reg_intr_state_de, rif.hw2reg_data_in_de,
                  rif.hw2reg_straps_data_in_valid_d, rif.hw2reg_straps_data_in_valid_de,
                  rif.hw2reg_straps_data_in_de},
        {27'h0, |ev, m_din_de, m_valid, m_sde, m_sde});
  end

  // ---------------- stimulus ----------------
  task automatic clear_regs();
    rif.reg2hw_intr_state_q = '0; rif.reg2hw_intr_enable_q = '0;
    rif.reg2hw_intr_test_q = '0; rif.reg2hw_intr_test_qe = 1'b0;
    rif.reg2hw_direct_out_q = '0; rif.reg2hw_direct_out_qe = 1'b0;
    rif.reg2hw_masked_out_lower_mask_q = '0; rif.reg2hw_masked_out_lower_data_q = '0;
    rif.reg2hw_masked_out_lower_qe = 1'b0;
    rif.reg2hw_masked_out_upper_mask_q = '0; rif.reg2hw_masked_out_upper_data_q = '0;
    rif.reg2hw_masked_out_upper_qe = 1'b0;
    rif.reg2hw_direct_oe_q = '0; rif.reg2hw_direct_oe_qe = 1'b0;
    rif.reg2hw_masked_oe_lower_mask_q = '0; rif.reg2hw_masked_oe_lower_data_q = '0;
    rif.reg2hw_masked_oe_lower_qe = 1'b0;
    rif.reg2hw_masked_oe_upper_mask_q = '0; rif.reg2hw_masked_oe_upper_data_q = '0;
    rif.reg2hw_masked_oe_upper_qe = 1'b0;
    rif.reg2hw_intr_ctrl_en_rising_q = '0; rif.reg2hw_intr_ctrl_en_falling_q = '0;
    rif.reg2hw_intr_ctrl_en_lvlhigh_q = '0; rif.reg2hw_intr_ctrl_en_lvllow_q = '0;
    rif.reg2hw_ctrl_en_input_filter_q = '0;
  endtask

  task automatic clear_strobes();
    rif.reg2hw_direct_out_qe = 1'b0; rif.reg2hw_masked_out_lower_qe = 1'b0;
    rif.reg2hw_masked_out_upper_qe = 1'b0; rif.reg2hw_direct_oe_qe = 1'b0;
    rif.reg2hw_masked_oe_lower_qe = 1'b0; rif.reg2hw_masked_oe_upper_qe = 1'b0;
    rif.reg2hw_intr_test_qe = 1'b0;
  endtask

  initial begin
    int rise_at, fall_at;
    logic hi_seen;
    clear_regs();
    rst_n = 1'b0;
    pad   = 32'hA5A5_0F0F;
    #1;
    chk("rst_cio_o", cio_o, 32'h0);
    chk("rst_straps", rif.hw2reg_straps_data_in_d, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Strap capture: de pulses after the 4th edge following release
    repeat (3) @(posedge clk);
    #1 chk("strap_de_early", {31'h0, rif.hw2reg_straps_data_in_de}, 32'h0);
    @(posedge clk); #1;
    chk("strap_value", rif.hw2reg_straps_data_in_d, 32'hA5A5_0F0F);
    chk("strap_de_valid", {30'h0, rif.hw2reg_straps_data_in_valid_d,
                           rif.hw2reg_straps_data_in_de}, 32'h3);
    @(posedge clk); #1;
    chk("strap_de_once", {31'h0, rif.hw2reg_straps_data_in_de}, 32'h0);

    // Output register writes
    @(negedge clk);
    rif.reg2hw_direct_out_q = 32'hFFFF_0000; rif.reg2hw_direct_out_qe = 1'b1;
    @(negedge clk);
    clear_strobes();
    rif.reg2hw_masked_out_lower_mask_q = 16'h00FF; rif.reg2hw_masked_out_lower_data_q = 16'h0055;
    rif.reg2hw_masked_out_lower_qe = 1'b1;
    @(posedge clk); #1 chk("masked_lower", cio_o, 32'hFFFF_0055);
    @(negedge clk);
    rif.reg2hw_direct_out_q = 32'h1234_5678; rif.reg2hw_direct_out_qe = 1'b1;
    rif.reg2hw_masked_out_lower_mask_q = 16'hFFFF; rif.reg2hw_masked_out_lower_data_q = 16'h0000;
    rif.reg2hw_masked_out_upper_mask_q = 16'hFFFF; rif.reg2hw_masked_out_upper_data_q = 16'hFFFF;
    rif.reg2hw_masked_out_upper_qe = 1'b1;
    @(posedge clk); #1 chk("direct_wins", cio_o, 32'h1234_5678);
    @(negedge clk);
    clear_strobes();
    rif.reg2hw_direct_oe_q = 32'h0000_FFFF; rif.reg2hw_direct_oe_qe = 1'b1;
    @(negedge clk);
    clear_strobes();
    rif.reg2hw_masked_oe_upper_mask_q = 16'hF0F0; rif.reg2hw_masked_oe_upper_data_q = 16'hFFFF;
    rif.reg2hw_masked_oe_upper_qe = 1'b1;
    @(posedge clk); #1 chk("masked_oe_upper", cio_en, 32'hF0F0_FFFF);
    @(negedge clk);
    clear_strobes();

    // Glitch filter on bit 3
    pad = '0;
    repeat (6) @(negedge clk);
    rif.reg2hw_ctrl_en_input_filter_q = 32'h8;
    hi_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); pad[3] = (i < 10);
      @(posedge clk); #1 if (rif.hw2reg_data_in_d[3]) hi_seen = 1'b1;
    end
    chk("glitch10_blocked", {31'h0, hi_seen}, 32'h0);
    rise_at = -1; fall_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); pad[3] = (i < 20);
      @(posedge clk); #1;
      if (rif.hw2reg_data_in_d[3] && rise_at < 0) rise_at = i;
      if (!rif.hw2reg_data_in_d[3] && rise_at >= 0 && fall_at < 0) fall_at = i;
    end
    chk("filter_rise_cycle", rise_at, 17);
    chk("filter_fall_cycle", fall_at, 37);

    // Rising-edge and low-level interrupts, filter off on bits 0/1
    @(negedge clk);
    rif.reg2hw_intr_ctrl_en_rising_q = 32'h1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (i == 0) pad[0] = 1'b1;
      @(posedge clk); #1;
      chk("rise_de", {31'h0, rif.hw2reg_intr_state_de}, (i == 2) ? 32'h1 : 32'h0);
      chk("rise_d0", {31'h0, rif.hw2reg_intr_state_d[0]}, (i == 2) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    rif.reg2hw_intr_ctrl_en_rising_q = '0;
    rif.reg2hw_intr_ctrl_en_lvllow_q = 32'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("lvllow_de", {31'h0, rif.hw2reg_intr_state_de}, 32'h1);
      chk("lvllow_d", rif.hw2reg_intr_state_d, 32'h2);
    end
    @(negedge clk);
    rif.reg2hw_intr_ctrl_en_lvllow_q = '0;

    // Software interrupt injection and interrupt outputs
    @(negedge clk);
    rif.reg2hw_intr_test_q = 32'h8000_0001; rif.reg2hw_intr_test_qe = 1'b1;
    #1;
    chk("intr_test_d", rif.hw2reg_intr_state_d, 32'h8000_0001);
    chk("intr_test_de", {31'h0, rif.hw2reg_intr_state_de}, 32'h1);
    @(negedge clk);
    rif.reg2hw_intr_test_qe = 1'b0;
    rif.reg2hw_intr_state_q = 32'h8000_0001; rif.reg2hw_intr_enable_q = 32'h1;
    #1;
    chk("intr_test_de_off", {31'h0, rif.hw2reg_intr_state_de}, 32'h0);
    chk("intr_gpio", intr_o, 32'h0000_0001);

    // Reset mid filter count, then strap recapture
    @(negedge clk);
    pad = 32'h1234_5678;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cio", cio_o | cio_en, 32'h0);
    chk("midrst_intr", intr_o | rif.hw2reg_intr_state_d, 32'h0);
    chk("midrst_data", rif.hw2reg_data_in_d | rif.hw2reg_straps_data_in_d, 32'h0);
    chk("midrst_flags", {29'h0, rif.hw2reg_straps_data_in_valid_d, rif.hw2reg_data_in_de,
                         rif.hw2reg_intr_state_de}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("recapture_value", rif.hw2reg_straps_data_in_d, 32'h1234_5670);
    chk("recapture_de", {31'h0, rif.hw2reg_straps_data_in_de}, 32'h1);
    repeat (20) @(negedge clk);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      pad ^= $urandom & $urandom & $urandom;
      rif.reg2hw_direct_out_qe = ($urandom_range(0, 15) == 0);
      rif.reg2hw_direct_out_q  = $urandom;
      rif.reg2hw_masked_out_lower_qe = ($urandom_range(0, 5) == 0);
      rif.reg2hw_masked_out_lower_mask_q = 16'($urandom);
      rif.reg2hw_masked_out_lower_data_q = 16'($urandom);
      rif.reg2hw_masked_out_upper_qe = ($urandom_range(0, 5) == 0);
      rif.reg2hw_masked_out_upper_mask_q = 16'($urandom);
      rif.reg2hw_masked_out_upper_data_q = 16'($urandom);
      rif.reg2hw_direct_oe_qe = ($urandom_range(0, 15) == 0);
      rif.reg2hw_direct_oe_q  = $urandom;
      rif.reg2hw_masked_oe_lower_qe = ($urandom_range(0, 5) == 0);
      rif.reg2hw_masked_oe_lower_mask_q = 16'($urandom);
      rif.reg2hw_masked_oe_lower_data_q = 16'($urandom);
      rif.reg2hw_masked_oe_upper_qe = ($urandom_range(0, 5) == 0);
      rif.reg2hw_masked_oe_upper_mask_q = 16'($urandom);
      rif.reg2hw_masked_oe_upper_data_q = 16'($urandom);
      if ($urandom_range(0, 63) == 0) rif.reg2hw_ctrl_en_input_filter_q = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        rif.reg2hw_intr_ctrl_en_rising_q  = $urandom;
        rif.reg2hw_intr_ctrl_en_falling_q = $urandom;
        rif.reg2hw_intr_ctrl_en_lvlhigh_q = $urandom & $urandom & $urandom;
        rif.reg2hw_intr_ctrl_en_lvllow_q  = $urandom & $urandom & $urandom;
      end
      rif.reg2hw_intr_state_q  = $urandom;
      rif.reg2hw_intr_enable_q = $urandom;
      rif.reg2hw_intr_test_qe  = ($urandom_range(0, 7) == 0);
      rif.reg2hw_intr_test_q   = $urandom;
      if (c == 700) rst_n = 1'b0;
      if (c == 704) rst_n = 1'b1;
    end
    @(negedge clk);
    clear_strobes();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
